depthwise_scheduler: RTL and testbench

Sequencer for the depthwise stage. It owns the layer-start handshake with the layer window and paces the pixel window across every output position of a feature map. For each position it steps the channel-group select and issues one 3×3×CHANNEL_PARALLELISM batch per cycle to the DSU, with `dsu_ready` back-pressure. It also raises the layer-done pulse.

---
 rtl/depthwise_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_depthwise_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depthwise_scheduler.sv
// depthwise_scheduler
// ---------------------------------------------------------------------------
// Sequencer for the depthwise stage. It performs the layer-start handshake with
// the layer window and steps the pixel window across every output position.
// At each position it walks the channel groups and issues one
// 3x3xCHANNEL_PARALLELISM batch per accepted cycle to the DSU.
//
// Build option: define DWS_STALL_COUNT_EN to build the stall_cycles counter.
// Without it, stall_cycles is tied to zero. The port list is the same in both
// builds.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle layer start (accepted only when idle)
//   input_size[7:0]     unpadded feature width/height, latched at start
//   channel[7:0]        channel count, latched at start (0 means one group)
//   buffer_ready        layer window finished its initial row load
//   window_first        pixel window has produced the first window
//   window_done         pixel window has produced the next window (level)
//   dsu_ready           DSU accepts a batch this cycle
//   init_buffer         init request to the layer/pixel windows
//   depthwise_en        pulse on the first group issue of a position
//   first_cycle         high on the issue of the last channel group
//   depth_channel_sel   base channel of the current group
//   dsu_valid           issue delayed one cycle (aligned with window data)
//   out_h, out_w        current output position
//   busy                a layer is in progress
//   layer_done          one-cycle pulse after the last position
//   stall_cycles[15:0]  stall counter (zero unless DWS_STALL_COUNT_EN)
// ---------------------------------------------------------------------------
module depthwise_scheduler #(
  parameter int CHANNEL_PARALLELISM = 4,
  parameter int PADDING             = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  input_size,
  input  logic [7:0]  channel,
  input  logic        buffer_ready,
  input  logic        window_first,
  input  logic        window_done,
  input  logic        dsu_ready,
  output logic        init_buffer,
  output logic        depthwise_en,
  output logic        first_cycle,
  output logic [7:0]  depth_channel_sel,
  output logic        dsu_valid,
  output logic [7:0]  out_h,
  output logic [7:0]  out_w,
  output logic        busy,
  output logic        layer_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_WIN,
    ISSUE,
    FINISH
  } state_t;

  localparam logic [7:0] CP8  = 8'(CHANNEL_PARALLELISM);
  localparam logic [8:0] PAD2 = 9'(2 * PADDING);

  state_t     state, next_state;
  logic [7:0] size_q;
  logic [7:0] last_sel_q;
  logic [7:0] sel_q;
  logic [7:0] h_q, w_q;
  logic       cfg_err_q;
  logic       win_seen_q;
  logic       dsu_valid_q;

  // Values latched at start.
  logic [7:0] ch_eff;
  logic [7:0] last_sel_calc;
  logic       cfg_err_calc;

  always_comb begin
    ch_eff        = (channel == 8'd0) ? CP8 : channel;
    // The base of the last group is (ceil(ch/CP) - 1) * CP = floor((ch-1)/CP) * CP.
    last_sel_calc = ((ch_eff - 8'd1) / CP8) * CP8;
    cfg_err_calc  = (input_size == 8'd0) || (({1'b0, input_size} + PAD2) > 9'd255);
  end

  logic at_origin, last_col, last_row, last_grp, issue, win_ok, accept_start;

  assign at_origin    = (h_q == 8'd0) && (w_q == 8'd0);
  assign last_col     = (w_q == size_q - 8'd1);
  assign last_row     = (h_q == size_q - 8'd1);
  assign last_grp     = (sel_q == last_sel_q);
  assign issue        = (state == ISSUE) && dsu_ready;
  assign accept_start = (state == IDLE) && start;
  // window_done is a level that can still be high from the previous position.
  // For that reason it is ignored on the first WAIT_WIN cycle. window_first is
  // a fresh event and is accepted at once.
  assign win_ok       = at_origin ? window_first : (window_done && win_seen_q);

  // NOTE: every flop resets asynchronously, and every sequential assignment is
  // non-blocking. Flops that are read in the same edge therefore see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: each output of this block gets a default first. This prevents a latch
  // on any path that does not assign the output.
  always_comb begin
    next_state   = state;
    init_buffer  = 1'b0;
    depthwise_en = 1'b0;
    first_cycle  = 1'b0;
    busy         = (state != IDLE);
    layer_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next_state = INIT;
      end
      INIT: begin
        init_buffer = 1'b1;
        if (buffer_ready) next_state = cfg_err_q ? FINISH : WAIT_WIN;
      end
      WAIT_WIN: begin
        if (win_ok) next_state = ISSUE;
      end
      ISSUE: begin
        depthwise_en = issue && (sel_q == 8'd0);
        first_cycle  = issue && last_grp;
        if (issue && last_grp) next_state = (last_row && last_col) ? FINISH : WAIT_WIN;
      end
      FINISH: begin
        layer_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q      <= '0;
      last_sel_q  <= '0;
      sel_q       <= '0;
      h_q         <= '0;
      w_q         <= '0;
      cfg_err_q   <= 1'b0;
      win_seen_q  <= 1'b0;
      dsu_valid_q <= 1'b0;
    end else begin
      dsu_valid_q <= issue;
      win_seen_q  <= (state == WAIT_WIN) && (next_state == WAIT_WIN);
      if (accept_start) begin
        size_q     <= input_size;
        last_sel_q <= last_sel_calc;
        cfg_err_q  <= cfg_err_calc;
        sel_q      <= '0;
        h_q        <= '0;
        w_q        <= '0;
      end
      if (issue) begin
        if (last_grp) begin
          sel_q <= '0;
          // The final position is held so that it stays visible after the layer.
          if (!(last_row && last_col)) begin
            if (last_col) begin
              w_q <= '0;
              h_q <= h_q + 8'd1;
            end else begin
              w_q <= w_q + 8'd1;
            end
          end
        end else begin
          sel_q <= sel_q + CP8;
        end
      end
    end
  end

  assign depth_channel_sel = sel_q;
  assign out_h             = h_q;
  assign out_w             = w_q;
  assign dsu_valid         = dsu_valid_q;

`ifdef DWS_STALL_COUNT_EN
  // A stall is an ISSUE cycle that the DSU refuses, or a WAIT_WIN cycle after
  // the guard cycle in which the window is still not ready.
  logic [15:0] stall_q;
  logic        stall_evt;

  assign stall_evt = ((state == ISSUE) && !dsu_ready) ||
                     ((state == WAIT_WIN) && win_seen_q && !win_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_q <= '0;
    else if (accept_start)                    stall_q <= '0;
    else if (stall_evt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_depthwise_scheduler.sv
// Self-checking bench for depthwise_scheduler.
// Before each layer runs, the bench builds a plan for it. The plan has random
// INIT lengths, window delays, stale window_done levels, DSU stalls and ignored
// start pulses. From that plan the bench generates both the stimulus and the
// expected outputs for every cycle. A layer is expanded from position/group
// loops, and the state machine is not modelled.
module tb_depthwise_scheduler;

  localparam int CP  = 4;
  localparam int PAD = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  input_size;
  logic [7:0]  channel;
  logic        buffer_ready;
  logic        window_first;
  logic        window_done;
  logic        dsu_ready;
  logic        init_buffer;
  logic        depthwise_en;
  logic        first_cycle;
  logic [7:0]  depth_channel_sel;
  logic        dsu_valid;
  logic [7:0]  out_h;
  logic [7:0]  out_w;
  logic        busy;
  logic        layer_done;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  depthwise_scheduler #(
    .CHANNEL_PARALLELISM(CP),
    .PADDING            (PAD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .input_size       (input_size),
    .channel          (channel),
    .buffer_ready     (buffer_ready),
    .window_first     (window_first),
    .window_done      (window_done),
    .dsu_ready        (dsu_ready),
    .init_buffer      (init_buffer),
    .depthwise_en     (depthwise_en),
    .first_cycle      (first_cycle),
    .depth_channel_sel(depth_channel_sel),
    .dsu_valid        (dsu_valid),
    .out_h            (out_h),
    .out_w            (out_w),
    .busy             (busy),
    .layer_done       (layer_done),
    .stall_cycles     (stall_cycles)
  );

  typedef struct {
    logic        start;
    logic [7:0]  size;
    logic [7:0]  ch;
    logic        buf_rdy;
    logic        win_first;
    logic        win_done;
    logic        rdy;
    logic        e_init;
    logic        e_den;
    logic        e_first;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic [7:0]  e_sel;
    logic [7:0]  e_h;
    logic [7:0]  e_w;
    logic [15:0] e_stall;
  } step_t;

  step_t      trace[$];
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;
  bit         prev_issue;
  int         st_acc;
  logic [7:0] cur_h, cur_w;
  bit         noise_start;
  int         mark;
  int         den_seen, done_seen;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // This is the default cycle: random junk on every input that should be ignored.
  // It expects a busy layer with no pulses at the current position.
  function automatic step_t blank();
    step_t s;
    s.start     = noise_start && ($urandom_range(0, 5) == 0);
    s.size      = 8'($urandom);
    s.ch        = 8'($urandom);
    s.buf_rdy   = 1'($urandom);
    s.win_first = 1'($urandom);
    s.win_done  = 1'($urandom);
    s.rdy       = 1'($urandom);
    s.e_init    = 1'b0;
    s.e_den     = 1'b0;
    s.e_first   = 1'b0;
    s.e_valid   = 1'b0;
    s.e_busy    = 1'b1;
    s.e_done    = 1'b0;
    s.e_sel     = 8'd0;
    s.e_h       = cur_h;
    s.e_w       = cur_w;
    s.e_stall   = 16'd0;
    return s;
  endfunction

  task automatic push(input step_t s, input bit issue, input bit stall_inc);
    s.e_valid = prev_issue;
`ifdef DWS_STALL_COUNT_EN
    s.e_stall = 16'(st_acc);
`else
    s.e_stall = 16'd0;
`endif
    trace.push_back(s);
    prev_issue = issue;
    if (s.start && !s.e_busy)            st_acc = 0;
    else if (stall_inc && st_acc < 65535) st_acc++;
  endtask

  // This task expands one layer into per-cycle steps.
  // If rnd=0, the layer runs with minimal waits. An optional stall of stall_len
  // cycles is then placed before group stall_grp of position (0,0).
  task automatic build_layer(input int n, input int ch, input bit rnd,
                             input int stall_grp, input int stall_len, input bit stale);
    step_t s;
    int    g_cnt, d, sl;
    bit    err;
    s = blank();
    s.start = 1'b1; s.size = 8'(n); s.ch = 8'(ch); s.e_busy = 1'b0;
    push(s, 0, 0);
    cur_h = 8'd0; cur_w = 8'd0;
    d = rnd ? $urandom_range(0, 3) : 0;
    for (int i = 0; i < d; i++) begin
      s = blank(); s.buf_rdy = 1'b0; s.e_init = 1'b1; s.e_h = 8'd0; s.e_w = 8'd0;
      push(s, 0, 0);
    end
    s = blank(); s.buf_rdy = 1'b1; s.e_init = 1'b1;
    push(s, 0, 0);
    g_cnt = (ch == 0) ? 1 : (ch + CP - 1) / CP;
    err   = (n == 0) || (n + 2 * PAD > 255);
    if (!err) begin
      for (int h = 0; h < n; h++) begin
        for (int w = 0; w < n; w++) begin
          cur_h = 8'(h); cur_w = 8'(w);
          if (h == 0 && w == 0) begin
            d = rnd ? $urandom_range(0, 3) : 0;
            for (int i = 0; i < d; i++) begin
              s = blank(); s.win_first = 1'b0;
              push(s, 0, i >= 1);
            end
            s = blank(); s.win_first = 1'b1;
            push(s, 0, 0);
          end else begin
            s = blank();
            if (stale) s.win_done = 1'b1;
            push(s, 0, 0);
            d = rnd ? $urandom_range(0, 3) : (stale ? 2 : 0);
            for (int i = 0; i < d; i++) begin
              s = blank(); s.win_done = 1'b0;
              push(s, 0, 1);
            end
            s = blank(); s.win_done = 1'b1;
            push(s, 0, 0);
          end
          for (int g = 0; g < g_cnt; g++) begin
            if (!rnd && h == 0 && w == 0 && g == stall_grp) sl = stall_len;
            else if (rnd && $urandom_range(0, 3) == 0)      sl = $urandom_range(1, 3);
            else                                           sl = 0;
            if (h == 1 && w == 1 && g == 2) mark = trace.size();
            for (int i = 0; i < sl; i++) begin
              s = blank(); s.rdy = 1'b0; s.e_sel = 8'(g * CP);
              push(s, 0, 1);
            end
            s = blank(); s.rdy = 1'b1; s.e_sel = 8'(g * CP);
            s.e_den = (g == 0); s.e_first = (g == g_cnt - 1);
            push(s, 1, 0);
          end
        end
      end
    end
    s = blank(); s.e_done = 1'b1;
    push(s, 0, 0);
    s = blank(); s.start = 1'b0; s.e_busy = 1'b0;
    push(s, 0, 0);
  endtask

  task automatic play(input int count);
    step_t s;
    for (int k = 0; k < count && trace.size() > 0; k++) begin
      s = trace.pop_front();
      @(posedge clk);
      #1;
      start        = s.start;
      input_size   = s.size;
      channel      = s.ch;
      buffer_ready = s.buf_rdy;
      window_first = s.win_first;
      window_done  = s.win_done;
      dsu_ready    = s.rdy;
      @(negedge clk);
      check($sformatf("init_buffer@%0d", step_no), 16'(init_buffer), 16'(s.e_init));
      check($sformatf("depthwise_en@%0d", step_no), 16'(depthwise_en), 16'(s.e_den));
      check($sformatf("first_cycle@%0d", step_no), 16'(first_cycle), 16'(s.e_first));
      check($sformatf("sel@%0d", step_no), 16'(depth_channel_sel), 16'(s.e_sel));
      check($sformatf("dsu_valid@%0d", step_no), 16'(dsu_valid), 16'(s.e_valid));
      check($sformatf("out_h@%0d", step_no), 16'(out_h), 16'(s.e_h));
      check($sformatf("out_w@%0d", step_no), 16'(out_w), 16'(s.e_w));
      check($sformatf("busy@%0d", step_no), 16'(busy), 16'(s.e_busy));
      check($sformatf("layer_done@%0d", step_no), 16'(layer_done), 16'(s.e_done));
      check($sformatf("stall@%0d", step_no), stall_cycles, s.e_stall);
      if (depthwise_en === 1'b1) den_seen++;
      if (layer_done === 1'b1)   done_seen++;
      step_no++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init"}, 16'(init_buffer), 16'd0);
    check({tag, "_den"}, 16'(depthwise_en), 16'd0);
    check({tag, "_first"}, 16'(first_cycle), 16'd0);
    check({tag, "_sel"}, 16'(depth_channel_sel), 16'd0);
    check({tag, "_valid"}, 16'(dsu_valid), 16'd0);
    check({tag, "_h"}, 16'(out_h), 16'd0);
    check({tag, "_w"}, 16'(out_w), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(layer_done), 16'd0);
    check({tag, "_stall"}, stall_cycles, 16'd0);
  endtask

  task automatic reset_model();
    prev_issue = 1'b0; st_acc = 0; cur_h = 8'd0; cur_w = 8'd0;
  endtask

  initial begin
    step_t s;
    rst_n = 1'b0; start = 1'b0; input_size = 8'd0; channel = 8'd0;
    buffer_ready = 1'b0; window_first = 1'b0; window_done = 1'b0; dsu_ready = 1'b0;
    noise_start = 1'b0; mark = -1; den_seen = 0; done_seen = 0;
    reset_model();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Idle cycles with junk inputs: nothing must happen.
    for (int i = 0; i < 3; i++) begin
      s = blank(); s.start = 1'b0; s.e_busy = 1'b0;
      push(s, 0, 0);
    end
    play(trace.size());

    // 3x3 map with 16 channels, no stalls: 9 positions x groups 0,4,8,12.
    den_seen = 0; done_seen = 0;
    build_layer(3, 16, 0, -1, 0, 0);
    play(trace.size());
    check("en_count_3x3", 16'(den_seen), 16'd9);
    check("done_count_3x3", 16'(done_seen), 16'd1);

    // Single group: 4 channels, then 0 channels (treated as one group).
    build_layer(2, 4, 0, -1, 0, 0);
    play(trace.size());
    build_layer(2, 0, 0, -1, 0, 0);
    play(trace.size());

    // DSU stall of 3 cycles at group 8, and stale window_done at later positions.
    build_layer(3, 16, 0, 2, 3, 1);
    play(trace.size());

    // start pulses while busy must be ignored; only one layer_done is expected.
    noise_start = 1'b1; done_seen = 0;
    build_layer(3, 12, 1, -1, 0, 0);
    play(trace.size());
    check("done_count_noise", 16'(done_seen), 16'd1);
    noise_start = 1'b0;

    // Configuration errors finish immediately after buffer_ready.
    build_layer(0, 8, 1, -1, 0, 0);
    play(trace.size());
    build_layer(254, 8, 1, -1, 0, 0);
    play(trace.size());

    // Reset in the middle of ISSUE, then a fresh layer.
    mark = -1;
    build_layer(4, 16, 0, -1, 0, 0);
    play(mark);
    @(posedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0;
    #2;
    check_all_zero("midrst");
    trace.delete();
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    den_seen = 0; done_seen = 0;
    build_layer(2, 16, 1, -1, 0, 0);
    play(trace.size());
    check("en_count_after_rst", 16'(den_seen), 16'd4);
    check("done_count_after_rst", 16'(done_seen), 16'd1);

    // Random layers.
    for (int l = 0; l < 6; l++) begin
      build_layer($urandom_range(1, 5), $urandom_range(0, 40), 1, -1, 0, 0);
      play(trace.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
